pattern_trigger: RTL and testbench
==================================

# pattern_trigger

Per-voice drum pattern store and trigger generator sitting directly downstream of the step sequencer. It consumes the sequencer's 8-bit one-hot step position and holds an 8-step on/off pattern for each voice. On every step advance while playing, it fires a fixed-length trigger pulse on each voice whose pattern bit is set for the new step. It also lets the user toggle pattern bits at the current step and drives the pattern display LEDs for the selected voice.

## Interface
Parameters:
- N_VOICES, 4: number of drum voices (1..8)
- TRIG_LEN, 16: trigger pulse length in clk cycles (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- seq_in  in  8  one-hot step position from sequencer; bit 7 = step 0, bit 0 = step 7
- play  in  1  level; 1 = playback enabled
- voice_sel  in  3  voice selected for edit/display; values ≥ N_VOICES are ignored
- edit_tgl  in  1  single-cycle pulse; toggles the selected voice's bit at the current step
- clr  in  1  single-cycle pulse; clears all patterns
- trig  out  N_VOICES  per-voice trigger pulses
- step_idx  out  3  registered binary index of current valid step
- pat_leds  out  8  selected voice's pattern, same bit order as seq_in

## Operation
- The pattern store is N_VOICES × 8 bits, cleared by reset and by clr.
- seq_q holds the registered copy of seq_in. It resets to 8'b1000_0000. play_q holds the registered copy of play and resets to 0.
- valid = seq_in has exactly one bit set. An invalid seq_in is ignored: seq_q, step_idx and the pattern are unchanged, no event fires, and edit_tgl is dropped.
- step_event = valid & play & ((seq_in != seq_q) | (play & ~play_q)).
  - A rising edge of play fires the current step.
- On step_event, each voice v with pattern[v][idx(seq_in)] = 1 starts or restarts its pulse. idx(seq_in) = 7 − bit position.
- Per-voice FSM, one per voice:
  - IDLE: trig low. Goes to FIRE on fire, loading the counter with TRIG_LEN.
  - FIRE: trig high. Counter decrements each cycle. Returns to IDLE when the counter reaches 1 with no new fire.
  - A new fire in FIRE reloads the counter to TRIG_LEN. Pulses merge and there is no low gap.
- play = 0 does not truncate active pulses. They run to completion.
- Edit: edit_tgl with valid seq_in and voice_sel < N_VOICES inverts pattern[voice_sel][idx(seq_in)]. This works whether or not playing.
- Simultaneous events in the same cycle:
  - step_event + edit_tgl on the same bit: the trigger decision uses the pre-toggle value. The toggle takes effect at the clock edge.
  - clr + edit_tgl: clr wins and the pattern ends all-zero.
  - clr + step_event: the trigger uses the pre-clear pattern.
- pat_leds = pattern[voice_sel], registered. It is 0 when voice_sel ≥ N_VOICES.

## Timing
- Reset values: trig = 0, step_idx = 0, pat_leds = 0, all FSMs in IDLE, all counters 0.
- step_event evaluated in cycle n gives trig high from cycle n+1 through n+TRIG_LEN inclusive, i.e. exactly TRIG_LEN cycles.
- step_idx updates in cycle n+1 after a valid seq_in change in cycle n.
- An edit_tgl in cycle n is visible on pat_leds in cycle n+1. A voice_sel change in cycle n is reflected in cycle n+1.
- Wrap-around is handled by the change detect alone: 0000_0001 → 1000_0000 is an ordinary step.
- Reset asserted mid-pulse drops trig on the next edge. A pattern being edited is lost.
- After reset is released with play already 1, play_q = 0, so the first enabled cycle fires step 0.

## Structure
- Shared package drum_pkg:
  - N_STEPS = 8
  - step_oh_t (logic [7:0])
  - step_idx_t (logic [2:0])
  - RESET_STEP = 8'b1000_0000
  - functions onehot_to_idx and is_onehot
- Sub-module trig_pulse holds the IDLE/FIRE FSM and counter for one voice. Its parameter is TRIG_LEN; its ports are clk, rst, fire, trig. It is instantiated N_VOICES times in a generate loop.
- The top level holds the pattern store, change detection, edit/clear logic and the LED mux.

## Test plan
- Reset, then set pattern[0] = steps 0 and 4 via edit_tgl. Play and step seq_in through 1000_0000 → … → 0000_0001 → 1000_0000 → trig[0] pulses of exactly 16 cycles at steps 4 and 0 only; trig[3:1] stay 0.
- play 0 → 1 while seq_in = 1000_0000 with pattern[1][0] = 1 → trig[1] rises the next cycle. Holding seq_in gives no further pulses.
- Step changes 5 cycles apart with the bit set (TRIG_LEN = 16) → trig stays high continuously until 16 cycles after the last step.
- seq_in = 0000_0000 or 1100_0000 with edit_tgl → pattern, step_idx and trig unchanged. Returning to a valid one-hot value that differs from seq_q fires.
- Same cycle step_event + edit_tgl on a set bit → trigger fires, and pat_leds shows the bit cleared next cycle. Same cycle clr + edit_tgl → pat_leds = 0.
- rst = 0 mid-pulse with a nonzero pattern → next cycle trig = 0, pat_leds = 0, step_idx = 0.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared types and helpers for the drum pattern blocks.
//   step_oh_t  : one-hot step position, bit 7 = step 0 ... bit 0 = step 7
//   step_idx_t : binary step index 0..7
//   RESET_STEP : step position assumed out of reset (step 0)
package drum_pkg;
  localparam int N_STEPS = 8;

  typedef logic [N_STEPS-1:0] step_oh_t;
  typedef logic [2:0]         step_idx_t;

  localparam step_oh_t RESET_STEP = 8'b1000_0000;

  function automatic logic is_onehot(input step_oh_t s);
    return (s != '0) && ((s & (s - 8'd1)) == '0);
  endfunction

  // Bit position p maps to step 7-p (MSB is step 0).
  function automatic step_idx_t onehot_to_idx(input step_oh_t s);
    step_idx_t r;
    r = '0;
    for (int i = 0; i < N_STEPS; i++)
      if (s[i]) r = step_idx_t'(N_STEPS - 1 - i);
    return r;
  endfunction
endpackage

// File: rtl/pattern_trigger_if.sv
// Bus between the control side (sequencer/UI) and pattern_trigger.
//   master : drives seq_in, play, voice_sel, edit_tgl, clr; sees trig/step_idx/pat_leds
//   slave  : the pattern_trigger block
interface pattern_trigger_if #(
  parameter int N_VOICES = 4
);
  import drum_pkg::*;

  step_oh_t              seq_in;
  logic                  play;
  logic [2:0]            voice_sel;
  logic                  edit_tgl;
  logic                  clr;
  logic [N_VOICES-1:0]   trig;
  step_idx_t             step_idx;
  step_oh_t              pat_leds;

  modport master (
    output seq_in, play, voice_sel, edit_tgl, clr,
    input  trig, step_idx, pat_leds
  );

  modport slave (
    input  seq_in, play, voice_sel, edit_tgl, clr,
    output trig, step_idx, pat_leds
  );
endinterface

// File: rtl/trig_pulse.sv
// Fixed-length trigger pulse generator for one voice.
//   clk, rst : clock, synchronous active-low reset
//   fire     : start (or restart) a pulse this cycle
//   trig     : registered pulse, high for exactly TRIG_LEN cycles after the last fire
module trig_pulse #(
  parameter int TRIG_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  output logic trig
);
  localparam int CW = $clog2(TRIG_LEN + 1);
  localparam logic [CW-1:0] LOAD = CW'(TRIG_LEN);

  typedef enum logic {IDLE, FIRE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      trig  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          state <= FIRE;
          cnt   <= LOAD;
          trig  <= 1'b1;
        end
        FIRE: begin
          // A re-fire reloads the count so overlapping pulses merge without a gap.
          if (fire) begin
            cnt <= LOAD;
          end else if (cnt == CW'(1)) begin
            state <= IDLE;
            cnt   <= '0;
            trig  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          trig  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/pattern_trigger.sv
// Per-voice 8-step pattern store and trigger generator.
//   clk, rst : clock, synchronous active-low reset
//   bus      : seq_in/play/voice_sel/edit_tgl/clr in; trig/step_idx/pat_leds out
// Patterns are stored in seq_in bit order so a step lookup is a mask with seq_in.
module pattern_trigger
  import drum_pkg::*;
#(
  parameter int N_VOICES = 4,
  parameter int TRIG_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  pattern_trigger_if.slave   bus
);
  step_oh_t                           seq_q;
  logic                               play_q;
  step_idx_t                          step_idx;
  step_oh_t                           pat_leds;
  logic [N_VOICES-1:0][N_STEPS-1:0]   pattern, pattern_nxt;
  logic [N_VOICES-1:0]                fire, trig;
  logic                               valid, step_event, edit_ok;
  step_oh_t                           leds_nxt;

  assign valid      = is_onehot(bus.seq_in);
  // Play rising edge re-fires the current step even when seq_in is unchanged.
  assign step_event = valid & bus.play & ((bus.seq_in != seq_q) | ~play_q);
  assign edit_ok    = bus.edit_tgl & valid;

  // Trigger decision uses the stored pattern, i.e. before any same-cycle edit/clear.
  always_comb begin
    fire = '0;
    for (int v = 0; v < N_VOICES; v++)
      fire[v] = step_event & (|(pattern[v] & bus.seq_in));
  end

  always_comb begin
    pattern_nxt = pattern;
    if (bus.clr) begin
      pattern_nxt = '0;
    end else begin
      for (int v = 0; v < N_VOICES; v++)
        if (edit_ok && bus.voice_sel == 3'(v))
          pattern_nxt[v] = pattern[v] ^ bus.seq_in;
    end
  end

  // LEDs follow the post-edit pattern so an edit shows up one cycle later.
  always_comb begin
    leds_nxt = '0;
    for (int v = 0; v < N_VOICES; v++)
      if (bus.voice_sel == 3'(v)) leds_nxt = pattern_nxt[v];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seq_q    <= RESET_STEP;
      play_q   <= 1'b0;
      step_idx <= '0;
      pattern  <= '0;
      pat_leds <= '0;
    end else begin
      play_q   <= bus.play;
      pattern  <= pattern_nxt;
      pat_leds <= leds_nxt;
      if (valid) begin
        seq_q    <= bus.seq_in;
        step_idx <= onehot_to_idx(bus.seq_in);
      end
    end
  end

  for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
    trig_pulse #(.TRIG_LEN(TRIG_LEN)) u_pulse (
      .clk  (clk),
      .rst  (rst),
      .fire (fire[v]),
      .trig (trig[v])
    );
  end

  assign bus.trig     = trig;
  assign bus.step_idx = step_idx;
  assign bus.pat_leds = pat_leds;
endmodule

// File: tb/tb_pattern_trigger.sv
// Directed + randomized bench for pattern_trigger with a step-level reference model.
module tb_pattern_trigger;
  localparam int NV = 4;
  localparam int TL = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_trigger_if #(.N_VOICES(NV)) bus ();

  pattern_trigger #(.N_VOICES(NV), .TRIG_LEN(TL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: pattern as [voice][step index], pulse as remaining cycles.
  bit pat [NV][8];
  int rem [NV];
  int m_idx;
  bit m_play_q;
  logic [7:0] exp_leds;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      rem[v] = 0;
      for (int s = 0; s < 8; s++) pat[v][s] = 0;
    end
    m_idx = 0;
    m_play_q = 0;
  endtask

  // Advance one clock: update the model from current inputs, then compare outputs.
  task automatic cyc();
    bit vld, ev;
    int idx, vs;
    logic [7:0] tx;
    vld = ($countones(bus.seq_in) == 1);
    idx = 0;
    for (int i = 0; i < 8; i++) if (bus.seq_in[i]) idx = 7 - i;
    vs = int'(bus.voice_sel);
    if (!rst) begin
      model_reset();
    end else begin
      ev = vld && bus.play && (idx != m_idx || !m_play_q);
      for (int v = 0; v < NV; v++)
        if (ev && pat[v][idx]) rem[v] = TL;
        else if (rem[v] > 0) rem[v]--;
      if (bus.clr) begin
        for (int v = 0; v < NV; v++) for (int s = 0; s < 8; s++) pat[v][s] = 0;
      end else if (bus.edit_tgl && vld && vs < NV) begin
        pat[vs][idx] = !pat[vs][idx];
      end
      if (vld) m_idx = idx;
      m_play_q = bus.play;
    end
    exp_leds = '0;
    if (rst && vs < NV)
      for (int s = 0; s < 8; s++) exp_leds[7-s] = pat[vs][s];
    tx = '0;
    for (int v = 0; v < NV; v++) tx[v] = (rem[v] > 0);
    @(posedge clk);
    #1;
    check("trig", 8'(bus.trig), tx);
    check("step_idx", 8'(bus.step_idx), 8'(m_idx));
    check("pat_leds", bus.pat_leds, exp_leds);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // One-cycle edit pulse at the given step for the given voice.
  task automatic toggle(input logic [2:0] vs, input logic [7:0] s);
    bus.voice_sel = vs;
    bus.seq_in = s;
    bus.edit_tgl = 1'b1;
    cyc();
    bus.edit_tgl = 1'b0;
  endtask

  int hi_run;

  initial begin
    model_reset();
    rst = 1'b0;
    bus.seq_in = 8'h80;
    bus.play = 1'b0;
    bus.voice_sel = 3'd0;
    bus.edit_tgl = 1'b0;
    bus.clr = 1'b0;
    run(2);
    rst = 1'b1;
    run(1);

    // Voice 0: steps 0 and 4, then play a full bar plus wrap.
    toggle(3'd0, 8'h80);
    toggle(3'd0, 8'h08);
    bus.seq_in = 8'h80;
    run(1);
    bus.play = 1'b1;
    for (int s = 0; s < 9; s++) begin
      bus.seq_in = 8'h80 >> (s % 8);
      run(20);
    end

    // Play rising edge on an unchanged step fires it; holding gives nothing more.
    bus.play = 1'b0;
    run(2);
    toggle(3'd1, 8'h80);
    bus.play = 1'b1;
    run(25);

    // Merging pulses: voice 2 on every step, steps 5 cycles apart.
    bus.play = 1'b0;
    for (int s = 0; s < 8; s++) toggle(3'd2, 8'h80 >> s);
    bus.seq_in = 8'h01;
    run(1);
    bus.play = 1'b1;
    hi_run = 0;
    for (int s = 0; s < 8; s++) begin
      bus.seq_in = 8'h80 >> s;
      for (int c = 0; c < 5; c++) begin
        cyc();
        if (bus.trig[2]) hi_run++;
      end
    end
    for (int c = 0; c < 30; c++) begin
      cyc();
      if (bus.trig[2]) hi_run++;
    end
    // 8 steps 5 apart: 35 cycles between first and last, plus the final 16.
    check("merge_len", 8'(hi_run), 8'(35 + TL));

    // Invalid positions with edits are ignored; a valid new step then fires.
    bus.play = 1'b1;
    bus.seq_in = 8'h80;
    run(20);
    toggle(3'd0, 8'h00);
    toggle(3'd0, 8'hC0);
    run(3);
    bus.seq_in = 8'h08;
    run(20);

    // Step event + toggle of the same set bit: fires, LED shows it cleared.
    bus.seq_in = 8'h80;
    run(20);
    toggle(3'd0, 8'h08);
    run(3);
    // clr + edit in the same cycle: all-zero wins.
    bus.clr = 1'b1;
    toggle(3'd1, 8'h08);
    bus.clr = 1'b0;
    bus.voice_sel = 3'd1;
    run(2);

    // Out-of-range voice shows no LEDs.
    bus.play = 1'b0;
    toggle(3'd3, 8'h04);
    bus.voice_sel = 3'd5;
    run(2);
    toggle(3'd6, 8'h04);

    // Reset mid-pulse.
    bus.voice_sel = 3'd3;
    bus.seq_in = 8'h04;
    bus.play = 1'b1;
    run(4);
    rst = 1'b0;
    run(1);
    check("rst_trig", 8'(bus.trig), 8'h00);
    check("rst_leds", bus.pat_leds, 8'h00);
    check("rst_idx", 8'(bus.step_idx), 8'h00);
    rst = 1'b1;
    run(3);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40) bus.seq_in = (bus.seq_in == 8'h01 || $countones(bus.seq_in) != 1)
                               ? 8'h80 : (bus.seq_in >> 1);
      else if (r < 50) bus.seq_in = 8'h80 >> $urandom_range(0, 7);
      else if (r < 54) bus.seq_in = 8'($urandom);
      if ($urandom_range(0, 29) == 0) bus.play = ~bus.play;
      bus.voice_sel = ($urandom_range(0, 9) == 0) ? 3'($urandom) : bus.voice_sel;
      bus.edit_tgl = ($urandom_range(0, 3) == 0);
      bus.clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 299) != 0);
      cyc();
    end
    bus.edit_tgl = 1'b0;
    bus.clr = 1'b0;
    rst = 1'b1;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
